mux_scan_sequencer: RTL and testbench

- Upstream controller for the 8:1 select mux; drives its 3-bit select and consumes its 1-bit output.
- On `start`, steps `sel` through channels 0..7, waits a programmable settle time on each, then samples `mux_out`.
- Assembles the eight samples into an 8-bit frame and presents it on a valid/ready handshake.
- Single-shot or continuous scanning.

---
 rtl/mux_scan_sequencer_pkg.sv | 15 +
 rtl/mux_scan_sequencer_if.sv | 28 ++
 rtl/mux_scan_sequencer_dwell_counter.sv | 26 ++
 rtl/mux_scan_sequencer.sv | 146 ++++++++++++++
 tb/tb_mux_scan_sequencer.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/mux_scan_sequencer_pkg.sv
// Shared definitions for the mux scan sequencer: default geometry and FSM state encoding.
package mux_scan_sequencer_pkg;

    localparam int NUM_CH_DEF  = 8;
    localparam int SEL_W_DEF   = 3;
    localparam int DWELL_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// Scan-side bus: mux select/sample pair, scan control and the frame valid/ready handshake.
interface mux_scan_sequencer_if
    import mux_scan_sequencer_pkg::*;
#(
    parameter int NUM_CH  = NUM_CH_DEF,
    parameter int SEL_W   = SEL_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
);
    logic               start;
    logic               cont;
    logic [DWELL_W-1:0] dwell;
    logic               mux_out;
    logic [SEL_W-1:0]   sel;
    logic               busy;
    logic [NUM_CH-1:0]  frame;
    logic               frame_valid;
    logic               frame_ready;

    modport master (
        input  start, cont, dwell, mux_out, frame_ready,
        output sel, busy, frame, frame_valid
    );

    modport slave (
        output start, cont, dwell, mux_out, frame_ready,
        input  sel, busy, frame, frame_valid
    );
endinterface

// File: rtl/mux_scan_sequencer_dwell_counter.sv
// Loadable settle down-counter; saturates at zero so a long dwell can never underflow.
module dwell_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] cnt_r;

    // Counter register: load wins over decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && (cnt_r != '0)) begin
            cnt_r <= cnt_r - W'(1);
        end
    end

    assign zero = (cnt_r == '0);
endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps the 8:1 mux select through every channel, settles, samples, and hands the
// assembled frame downstream on valid/ready; optional back-to-back continuous scanning.
module mux_scan_sequencer
    import mux_scan_sequencer_pkg::*;
#(
    parameter int NUM_CH  = NUM_CH_DEF,
    parameter int SEL_W   = SEL_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    mux_scan_sequencer_if.master  bus
);
    state_t             state_r;
    state_t             state_nxt_s;
    logic [SEL_W-1:0]   sel_r;
    logic [NUM_CH-1:0]  work_r;
    logic [NUM_CH-1:0]  work_nxt_s;
    logic [NUM_CH-1:0]  frame_r;
    logic               frame_valid_r;
    logic               busy_r;
    logic [DWELL_W-1:0] dwell_lat_r;
    logic               cnt_load_s;
    logic [DWELL_W-1:0] cnt_load_val_s;
    logic               cnt_dec_s;
    logic               cnt_zero_s;
    logic               last_s;
    logic               handshake_s;

    assign last_s      = (sel_r == SEL_W'(NUM_CH - 1));
    assign handshake_s = frame_valid_r && bus.frame_ready;

    dwell_counter #(.W(DWELL_W)) u_dwell_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load_s),
        .load_val (cnt_load_val_s),
        .dec      (cnt_dec_s),
        .zero     (cnt_zero_s)
    );

    // Working register with the current channel's sample merged in.
    always_comb begin
        work_nxt_s        = work_r;
        work_nxt_s[sel_r] = bus.mux_out;
    end

    // Next-state and settle-counter control.
    always_comb begin
        state_nxt_s    = state_r;
        cnt_load_s     = 1'b0;
        cnt_load_val_s = dwell_lat_r;
        cnt_dec_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt_s    = ST_SETTLE;
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = bus.dwell;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_zero_s) begin
                    state_nxt_s = ST_SAMPLE;
                end else begin
                    state_nxt_s = ST_SETTLE;
                    cnt_dec_s   = 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (last_s) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_SETTLE;
                    cnt_load_s  = 1'b1;
                end
            end
            ST_HOLD: begin
                if (handshake_s && bus.cont) begin
                    state_nxt_s = ST_SETTLE;
                    cnt_load_s  = 1'b1;
                end else if (handshake_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, select, working/frame registers and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            busy_r        <= 1'b0;
            sel_r         <= '0;
            work_r        <= '0;
            frame_r       <= '0;
            frame_valid_r <= 1'b0;
            dwell_lat_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        sel_r       <= '0;
                        work_r      <= '0;
                        dwell_lat_r <= bus.dwell;
                    end
                end
                ST_SAMPLE: begin
                    work_r <= work_nxt_s;
                    if (last_s) begin
                        frame_r       <= work_nxt_s;
                        frame_valid_r <= 1'b1;
                    end else begin
                        sel_r <= sel_r + SEL_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (handshake_s) begin
                        frame_valid_r <= 1'b0;
                        // Continuous restart goes straight back to channel 0 with no IDLE gap.
                        if (bus.cont) begin
                            sel_r  <= '0;
                            work_r <= '0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.sel         = sel_r;
    assign bus.busy        = busy_r;
    assign bus.frame       = frame_r;
    assign bus.frame_valid = frame_valid_r;
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Randomized self-checking bench for mux_scan_sequencer; expectations come from scan timing arithmetic.
module tb_mux_scan_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] chan = 8'h00;
    int         total = 0;
    int         bad = 0;

    mux_scan_sequencer_if #(.NUM_CH(8), .SEL_W(3), .DWELL_W(4)) bus ();

    mux_scan_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural 8:1 mux: channel i drives bit i of chan.
    assign bus.mux_out = chan[bus.sel];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name, input logic [2:0] exp_sel, input logic [7:0] exp_frame);
        total++;
        if (bus.busy !== 1'b0 || bus.frame_valid !== 1'b0 || bus.sel !== exp_sel || bus.frame !== exp_frame) begin
            bad++;
            $display("FAIL %s: busy=%b valid=%b sel=%0d frame=%h, want busy=0 valid=0 sel=%0d frame=%h",
                     name, bus.busy, bus.frame_valid, bus.sel, bus.frame, exp_sel, exp_frame);
        end
    endtask

    // Accept a scan: start is seen in IDLE on this edge; dwell is scrambled afterwards.
    task automatic do_start(input logic [3:0] d);
        bus.start = 1'b1;
        bus.dwell = d;
        step();
        bus.start = 1'b0;
        bus.dwell = 4'($urandom);
        total++;
        if (bus.busy !== 1'b1 || bus.sel !== 3'd0 || bus.frame_valid !== 1'b0) begin
            bad++;
            $display("FAIL start_accept: busy=%b sel=%0d valid=%b, want busy=1 sel=0 valid=0",
                     bus.busy, bus.sel, bus.frame_valid);
        end
    endtask

    // Walk one whole scan from the accepting edge: each channel occupies dwell+2 edges,
    // frame_valid rises exactly on edge 8*(dwell+2).
    task automatic check_scan(input logic [3:0] d, input logic [7:0] ch, input bit poke);
        int per;
        int len;
        int exp_sel;
        logic rdy;
        per = int'(d) + 2;
        len = 8 * per;
        rdy = bus.frame_ready;
        for (int k = 1; k <= len; k++) begin
            if (poke && k == 2) begin
                bus.start = 1'b1;
                bus.frame_ready = 1'b1;
            end else begin
                bus.start = 1'b0;
                bus.frame_ready = rdy;
            end
            bus.dwell = 4'($urandom);
            step();
            exp_sel = (k / per > 7) ? 7 : k / per;
            total++;
            if (bus.sel !== 3'(exp_sel) || bus.busy !== 1'b1 || bus.frame_valid !== (k == len)) begin
                bad++;
                $display("FAIL scan_timing d=%0d edge=%0d: sel=%0d busy=%b valid=%b, want sel=%0d busy=1 valid=%b",
                         d, k, bus.sel, bus.busy, bus.frame_valid, exp_sel, (k == len));
            end
        end
        bus.start = 1'b0;
        bus.frame_ready = rdy;
        total++;
        if (bus.frame !== ch) begin
            bad++;
            $display("FAIL scan_frame d=%0d: frame=%h want %h", d, bus.frame, ch);
        end
    endtask

    // Complete the HOLD handshake with cont=0; a same-cycle start must not be seen.
    task automatic finish_frame(input bit with_start, input logic [7:0] ch);
        bus.cont = 1'b0;
        bus.frame_ready = 1'b1;
        bus.start = with_start;
        step();
        bus.start = 1'b0;
        bus.frame_ready = 1'b0;
        check_idle("handshake_to_idle", 3'd7, ch);
        step();
        check_idle("idle_after_handshake", 3'd7, ch);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle("reset_hold", 3'd0, 8'h00);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check_idle("reset_idle", 3'd0, 8'h00);
        end
    endtask

    task automatic test_single();
        chan = 8'b0100_1101;
        bus.cont = 1'b0;
        bus.frame_ready = 1'b1;
        do_start(4'd0);
        check_scan(4'd0, 8'b0100_1101, 1'b0);
        step();
        check_idle("single_busy_drop", 3'd7, 8'b0100_1101);
        bus.frame_ready = 1'b0;
    endtask

    task automatic test_settle_dwell3();
        chan = 8'($urandom);
        do_start(4'd3);
        check_scan(4'd3, chan, 1'b0);
        finish_frame(1'b0, chan);
    endtask

    task automatic test_backpressure_cont();
        logic [7:0] first;
        first = 8'($urandom);
        chan = first;
        bus.cont = 1'b1;
        bus.frame_ready = 1'b0;
        do_start(4'd0);
        check_scan(4'd0, first, 1'b0);
        chan = 8'hA5;
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if (bus.frame_valid !== 1'b1 || bus.frame !== first || bus.sel !== 3'd7 || bus.busy !== 1'b1) begin
                bad++;
                $display("FAIL backpressure_hold: valid=%b frame=%h sel=%0d busy=%b, want valid=1 frame=%h sel=7 busy=1",
                         bus.frame_valid, bus.frame, bus.sel, bus.busy, first);
            end
        end
        bus.frame_ready = 1'b1;
        step();
        bus.frame_ready = 1'b0;
        bus.cont = 1'b0;
        total++;
        if (bus.frame_valid !== 1'b0 || bus.sel !== 3'd0 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL cont_restart: valid=%b sel=%0d busy=%b, want valid=0 sel=0 busy=1",
                     bus.frame_valid, bus.sel, bus.busy);
        end
        check_scan(4'd0, 8'hA5, 1'b0);
        finish_frame(1'b0, 8'hA5);
    endtask

    task automatic test_midreset();
        logic [7:0] ch;
        do_start(4'd1);
        for (int k = 1; k <= 12; k++) begin
            step();
        end
        total++;
        if (bus.sel !== 3'd4 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL midreset_position: sel=%0d busy=%b, want sel=4 busy=1", bus.sel, bus.busy);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("midreset_clear", 3'd0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            step();
            check_idle("midreset_quiet", 3'd0, 8'h00);
        end
        ch = 8'($urandom);
        chan = ch;
        do_start(4'd1);
        check_scan(4'd1, ch, 1'b0);
        finish_frame(1'b0, ch);
    endtask

    task automatic test_ignored_inputs();
        logic [7:0] ch;
        logic [7:0] held;
        held = bus.frame;
        bus.frame_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_idle("ready_while_idle", 3'd7, held);
        end
        bus.frame_ready = 1'b0;
        ch = 8'($urandom);
        chan = ch;
        do_start(4'd2);
        check_scan(4'd2, ch, 1'b1);
        finish_frame(1'b1, ch);
    endtask

    task automatic test_random();
        logic [3:0] d;
        logic [7:0] ch;
        for (int n = 0; n < 6; n++) begin
            d = (n == 0) ? 4'hF : 4'($urandom_range(0, 15));
            ch = 8'($urandom);
            chan = ch;
            do_start(d);
            check_scan(d, ch, 1'b0);
            for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
                step();
            end
            finish_frame(n[0], ch);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.cont = 1'b0;
        bus.dwell = 4'd0;
        bus.frame_ready = 1'b0;
        test_reset();
        test_single();
        test_settle_dwell3();
        test_backpressure_cont();
        test_midreset();
        test_ignored_inputs();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
